// File: rtl/rdyval_fifo.sv
// rdyval_fifo: synchronous ready/valid FIFO with registered occupancy.
// Output comes straight from the storage array (no fall-through), so data
// accepted into an empty FIFO is presented on the cycle after acceptance.
// rdy depends only on registered state and flush, and vld_nxt only on
// registered state, so neither side has a combinational path to the other.
module rdyval_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     vld,
    output logic                     rdy,
    input  logic [DWIDTH-1:0]        i_dat,
    output logic                     vld_nxt,
    input  logic                     rdy_nxt,
    output logic [DWIDTH-1:0]        o_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Pointer wrap relies on DEPTH being an exact power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rdyval_fifo: DEPTH must be a power of two and >= 2");
    end
    if (DWIDTH < 1) begin : g_bad_width
        $error("rdyval_fifo: DWIDTH must be >= 1");
    end

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // Status flags and handshakes decoded from the registered occupancy.
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_empty = (r_count == '0);
        w_push  = vld & ~w_full & ~flush;
        // flush cancels a downstream transfer in the same cycle
        w_pop   = ~w_empty & rdy_nxt & ~flush;
    end

    assign rdy     = ~w_full & ~flush;
    assign vld_nxt = ~w_empty;
    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = r_count;
    assign o_dat   = r_mem[r_rptr];

    // Pointer and occupancy update; reset beats flush, flush beats transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

endmodule

// File: tb/tb_rdyval_fifo.sv
// Directed bench for rdyval_fifo (DWIDTH=32, DEPTH=4) with a queue scoreboard.
module tb_rdyval_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        vld;
    logic        rdy;
    logic [31:0] i_dat;
    logic        vld_nxt;
    logic        rdy_nxt;
    logic [31:0] o_dat;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    logic        last_push;
    logic        last_pop;
    int          npush;
    int          npop;
    int          budget;

    always #5 clk = ~clk;

    rdyval_fifo #(.DWIDTH(32), .DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .vld     (vld),
        .rdy     (rdy),
        .i_dat   (i_dat),
        .vld_nxt (vld_nxt),
        .rdy_nxt (rdy_nxt),
        .o_dat   (o_dat),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs, update model, check post-edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic rn,
                       input logic f, input logic rst);
        logic exp_rdy;
        logic exp_vld;
        logic do_push;
        logic do_pop;
        logic [31:0] dummy;
        vld     = v;
        i_dat   = d;
        rdy_nxt = rn;
        flush   = f;
        rst_n   = rst;
        #2;
        exp_vld = (q.size() > 0);
        exp_rdy = (q.size() < 4) && !f;
        chk("rdy_pre", {31'd0, rdy}, {31'd0, exp_rdy});
        chk("vld_nxt_pre", {31'd0, vld_nxt}, {31'd0, exp_vld});
        if (exp_vld) chk("o_dat", o_dat, q[0]);
        do_push = rst && !f && v && exp_rdy;
        do_pop  = rst && !f && rn && exp_vld;
        if (!rst || f) begin
            q.delete();
        end else begin
            if (do_pop) dummy = q.pop_front();
            if (do_push) q.push_back(d);
        end
        last_push = do_push;
        last_pop  = do_pop;
        @(posedge clk);
        #1;
        chk("count", {29'd0, count}, q.size());
        chk("full", {31'd0, full}, {31'd0, (q.size() == 4)});
        chk("empty", {31'd0, empty}, {31'd0, (q.size() == 0)});
        chk("vld_nxt_post", {31'd0, vld_nxt}, {31'd0, (q.size() > 0)});
        chk("rdy_post", {31'd0, rdy}, {31'd0, ((q.size() < 4) && !f)});
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        vld     = 1'b0;
        rdy_nxt = 1'b0;
        i_dat   = '0;
        last_push = 1'b0;
        last_pop  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_vld_nxt", {31'd0, vld_nxt}, 32'd0);
        chk("rst_rdy", {31'd0, rdy}, 32'd1);

        // fill and drain
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hA0 + i, 1'b0, 1'b0, 1'b1);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_rdy", {31'd0, rdy}, 32'd0);
        chk("fill_count", {29'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // streaming, one item per cycle
        for (int i = 1; i <= 10; i++) cyc(1'b1, i, 1'b1, 1'b0, 1'b1);
        chk("stream_count", {29'd0, count}, 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // full with simultaneous pop: push refused, then accepted
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hB0 + i, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'hB4, 1'b1, 1'b0, 1'b1);
        chk("fullpop_count", {29'd0, count}, 32'd3);
        cyc(1'b1, 32'hB4, 1'b0, 1'b0, 1'b1);
        chk("fullpop_count2", {29'd0, count}, 32'd4);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // wrap-around with random backpressure
        npush  = 0;
        npop   = 0;
        budget = 300;
        while (npop < 9 && budget > 0) begin
            cyc((npush < 9) && ($urandom_range(0, 1) == 1), 32'hC00 + npush,
                ($urandom_range(0, 1) == 1), 1'b0, 1'b1);
            if (last_push) npush++;
            if (last_pop) npop++;
            budget--;
        end
        chk("wrap_budget", {31'd0, (budget > 0)}, 32'd1);
        chk("wrap_empty", {31'd0, empty}, 32'd1);

        // flush with valid and ready asserted
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hD0 + i, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'hD3, 1'b1, 1'b1, 1'b1);
        chk("flush_count", {29'd0, count}, 32'd0);
        chk("flush_vld_nxt", {31'd0, vld_nxt}, 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // reset mid-stream, then confirm only fresh data emerges
        cyc(1'b1, 32'hE0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'hE1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'hE2, 1'b1, 1'b0, 1'b0);
        chk("midrst_count", {29'd0, count}, 32'd0);
        chk("midrst_vld_nxt", {31'd0, vld_nxt}, 32'd0);
        chk("midrst_rdy", {31'd0, rdy}, 32'd1);
        cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        chk("midrst_fresh", o_dat, 32'h55);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rdyval_fifo.md
RDYVAL_FIFO -- requirements
Module: rdyval_fifo

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, data width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of storage entries; it must be a power of two and >=2, and any other value SHALL cause an elaboration error.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; it is synchronous and active-low.
REQ-005 The block SHALL have port flush, input, 1, synchronous discard of all stored entries.
REQ-006 The block SHALL have port vld, input, 1, upstream valid.
REQ-007 The block SHALL have port rdy, output, 1, upstream ready.
REQ-008 The block SHALL have port i_dat, input, DWIDTH, upstream data.
REQ-009 The block SHALL have port vld_nxt, output, 1, downstream valid.
REQ-010 The block SHALL have port rdy_nxt, input, 1, downstream ready.
REQ-011 The block SHALL have port o_dat, output, DWIDTH, downstream data (head entry).
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-013 The block SHALL have ports full and empty, output, 1 each, status flags.

Function
REQ-014 Upstream transfer SHALL occur on a rising edge where vld & rdy; downstream transfer SHALL occur where vld_nxt & rdy_nxt.
REQ-015 rdy SHALL equal !full & !flush, with no combinational path from rdy_nxt or vld.
REQ-016 vld_nxt SHALL equal !empty, with no combinational path from vld or rdy_nxt.
REQ-017 Entries SHALL leave in acceptance order (FIFO), with no loss or duplication.
REQ-018 Latency SHALL be 1 cycle: data accepted at edge N SHALL appear on o_dat with vld_nxt=1 after edge N when the FIFO was empty; there is no fall-through.
REQ-019 o_dat and vld_nxt SHALL remain stable while vld_nxt=1 and rdy_nxt=0.
REQ-020 Write and read pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-021 count SHALL be +1 on an upstream-only transfer, -1 on a downstream-only transfer, and unchanged on a simultaneous transfer.
REQ-022 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both derived from registered state.
REQ-023 When full, no upstream transfer SHALL occur, even if a downstream transfer occurs in the same cycle.
REQ-024 When empty, a same-cycle upstream transfer SHALL NOT be bypassed to the output.
REQ-025 flush=1 at an edge SHALL set count=0, both pointers=0 and empty=1, SHALL override any same-cycle downstream transfer, and SHALL accept no input.
REQ-026 Storage contents SHALL need no reset; o_dat is don't-care while empty.

Reset
REQ-027 On a rising edge with rst_n=0, the block SHALL set pointers=0, count=0, empty=1, full=0, vld_nxt=0 and rdy=1 (if flush=0) after that edge.
REQ-028 Reset SHALL take priority over flush and any transfer, and a mid-operation reset SHALL discard all stored entries.
REQ-029 Outputs SHALL have the values of REQ-027 in the first cycle after rst_n returns high.

Verification (DWIDTH=32, DEPTH=4)
REQ-030 Fill-and-drain: push 0xA0..0xA3 with rdy_nxt=0 -> full=1, rdy=0, count=4; then rdy_nxt=1 -> outputs 0xA0,0xA1,0xA2,0xA3 in order, empty=1.
REQ-031 Streaming: vld=1 and rdy_nxt=1 continuously with data 1..10 -> after the first item, count stays 1, throughput is 1 item per cycle, and 1..10 appear in order.
REQ-032 Full with simultaneous pop: count=4, vld=1, rdy_nxt=1 -> new item not accepted, count=3, then accepted next cycle, count=4.
REQ-033 Wrap-around: 9 pushes and 9 pops with random backpressure -> pointers wrap twice and the data sequence is exact.
REQ-034 Flush: count=3, flush=1 with vld=1 and rdy_nxt=1 -> next cycle count=0, vld_nxt=0, no output transfer, input not accepted.
REQ-035 Reset mid-stream: count=2, rst_n=0 for 1 cycle -> count=0, vld_nxt=0, rdy=1, and old data never appears.
